// File: rtl/aes_round_ctrl_pkg.sv
// Shared types and constants for the AES-128 round sequencer.
package aes_ctrl_pkg;

   localparam int unsigned AES128_ROUNDS = 10;
   localparam int unsigned ROUND_W       = 4;

   typedef logic [ROUND_W-1:0] round_idx_t;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      KEXP     = 3'd1,
      INIT_ARK = 3'd2,
      ROUND    = 3'd3,
      FINAL    = 3'd4,
      DONE     = 3'd5
   } state_t;

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Host handshake plus datapath/key-demux control bundle of the round sequencer.
interface aes_round_ctrl_if #(
   parameter int unsigned ROUND_W = 4
);
   logic               start;
   logic               start_ready;
   logic               state_load;
   logic               key_wr;
   logic [ROUND_W-1:0] key_sel;
   logic [ROUND_W-1:0] rk_sel;
   logic               sub_en;
   logic               shift_en;
   logic               mix_en;
   logic               ark_en;
   logic               busy;
   logic               done_valid;
   logic               done_ready;

   // Host side: issues start and accepts the ciphertext.
   modport master (
      output start, done_ready,
      input  start_ready, state_load, key_wr, key_sel, rk_sel,
             sub_en, shift_en, mix_en, ark_en, busy, done_valid
   );

   // Sequencer side.
   modport slave (
      input  start, done_ready,
      output start_ready, state_load, key_wr, key_sel, rk_sel,
             sub_en, shift_en, mix_en, ark_en, busy, done_valid
   );
endinterface

// File: rtl/aes_round_ctrl_step_cnt.sv
// Modulo-CYCLES counter pacing each key-expansion step; clear wins over enable.
module aes_step_cnt #(
   parameter int unsigned CYCLES = 1,
   parameter int unsigned CNT_W  = (CYCLES > 1) ? $clog2(CYCLES) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_clr,
   input  logic             i_en,
   output logic [CNT_W-1:0] o_cnt_nxt,
   output logic             o_tc
);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_tc;

   assign w_tc      = (r_cnt == CNT_W'(CYCLES - 1));
   assign o_tc      = w_tc;
   assign o_cnt_nxt = w_cnt_nxt;

   // Next count: wrap to zero after the terminal count.
   always_comb begin
      w_cnt_nxt = r_cnt;
      if (i_clr) begin
         w_cnt_nxt = '0;
      end else if (i_en) begin
         w_cnt_nxt = w_tc ? '0 : r_cnt + CNT_W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_cnt_nxt;
      end
   end

endmodule

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: key expansion writes, initial ARK, full rounds, final round.
module aes_round_ctrl #(
   parameter int unsigned NUM_ROUNDS  = aes_ctrl_pkg::AES128_ROUNDS,
   parameter int unsigned ROUND_W     = aes_ctrl_pkg::ROUND_W,
   parameter int unsigned KEXP_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   aes_round_ctrl_if.slave  bus
);
   import aes_ctrl_pkg::*;

   localparam int unsigned CNT_W = (KEXP_CYCLES > 1) ? $clog2(KEXP_CYCLES) : 1;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [ROUND_W-1:0] r_key_idx;
   logic [ROUND_W-1:0] w_key_idx_nxt;
   logic [ROUND_W-1:0] r_round;
   logic [ROUND_W-1:0] w_round_nxt;

   logic               w_step_clr;
   logic               w_step_en;
   logic [CNT_W-1:0]   w_step_nxt;
   logic               w_step_tc;

   // Decoded outputs of the upcoming state, registered so the ports are glitch-free.
   logic               w_key_wr;
   logic [ROUND_W-1:0] w_key_sel;
   logic [ROUND_W-1:0] w_rk_sel;
   logic               w_sub_en;
   logic               w_shift_en;
   logic               w_mix_en;
   logic               w_ark_en;
   logic               w_busy;
   logic               w_done_valid;
   logic               w_start_ready;

   logic               r_key_wr;
   logic [ROUND_W-1:0] r_key_sel;
   logic [ROUND_W-1:0] r_rk_sel;
   logic               r_sub_en;
   logic               r_shift_en;
   logic               r_mix_en;
   logic               r_ark_en;
   logic               r_busy;
   logic               r_done_valid;
   logic               r_start_ready;

   aes_step_cnt #(
      .CYCLES (KEXP_CYCLES),
      .CNT_W  (CNT_W)
   ) u_step_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clr     (w_step_clr),
      .i_en      (w_step_en),
      .o_cnt_nxt (w_step_nxt),
      .o_tc      (w_step_tc)
   );

   // State and index registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_key_idx <= '0;
         r_round   <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_key_idx <= w_key_idx_nxt;
         r_round   <= w_round_nxt;
      end
   end

   // Next-state and index update.
   always_comb begin
      w_state_nxt   = r_state;
      w_key_idx_nxt = r_key_idx;
      w_round_nxt   = r_round;
      w_step_clr    = 1'b0;
      w_step_en     = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_state_nxt   = KEXP;
               w_key_idx_nxt = '0;
               w_step_clr    = 1'b1;
            end
         end
         KEXP: begin
            w_step_en = 1'b1;
            if (w_step_tc) begin
               if (r_key_idx == ROUND_W'(NUM_ROUNDS)) begin
                  w_state_nxt   = INIT_ARK;
                  w_key_idx_nxt = '0;
                  w_step_clr    = 1'b1;
               end else begin
                  w_key_idx_nxt = r_key_idx + ROUND_W'(1);
               end
            end
         end
         INIT_ARK: begin
            w_state_nxt = ROUND;
            w_round_nxt = ROUND_W'(1);
         end
         ROUND: begin
            if (r_round == ROUND_W'(NUM_ROUNDS - 1)) begin
               w_state_nxt = FINAL;
               w_round_nxt = ROUND_W'(NUM_ROUNDS);
            end else begin
               w_round_nxt = r_round + ROUND_W'(1);
            end
         end
         FINAL: begin
            w_state_nxt = DONE;
         end
         DONE: begin
            if (bus.done_ready) begin
               w_state_nxt = IDLE;
               w_round_nxt = '0;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Output decode of the state being entered; selects stay zero outside their owning states.
   always_comb begin
      w_key_wr      = 1'b0;
      w_key_sel     = '0;
      w_rk_sel      = '0;
      w_sub_en      = 1'b0;
      w_shift_en    = 1'b0;
      w_mix_en      = 1'b0;
      w_ark_en      = 1'b0;
      w_busy        = 1'b1;
      w_done_valid  = 1'b0;
      w_start_ready = 1'b0;
      case (w_state_nxt)
         IDLE: begin
            w_busy        = 1'b0;
            w_start_ready = 1'b1;
         end
         KEXP: begin
            w_key_wr  = (w_step_nxt == CNT_W'(KEXP_CYCLES - 1));
            w_key_sel = w_key_idx_nxt;
         end
         INIT_ARK: begin
            w_ark_en = 1'b1;
         end
         ROUND: begin
            w_sub_en   = 1'b1;
            w_shift_en = 1'b1;
            w_mix_en   = 1'b1;
            w_ark_en   = 1'b1;
            w_rk_sel   = w_round_nxt;
         end
         FINAL: begin
            w_sub_en   = 1'b1;
            w_shift_en = 1'b1;
            w_ark_en   = 1'b1;
            w_rk_sel   = ROUND_W'(NUM_ROUNDS);
         end
         DONE: begin
            w_done_valid = 1'b1;
         end
         default: begin
            w_busy = 1'b1;
         end
      endcase
   end

   // Output registers; reset forces the idle pattern immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_key_wr      <= 1'b0;
         r_key_sel     <= '0;
         r_rk_sel      <= '0;
         r_sub_en      <= 1'b0;
         r_shift_en    <= 1'b0;
         r_mix_en      <= 1'b0;
         r_ark_en      <= 1'b0;
         r_busy        <= 1'b0;
         r_done_valid  <= 1'b0;
         r_start_ready <= 1'b1;
      end else begin
         r_key_wr      <= w_key_wr;
         r_key_sel     <= w_key_sel;
         r_rk_sel      <= w_rk_sel;
         r_sub_en      <= w_sub_en;
         r_shift_en    <= w_shift_en;
         r_mix_en      <= w_mix_en;
         r_ark_en      <= w_ark_en;
         r_busy        <= w_busy;
         r_done_valid  <= w_done_valid;
         r_start_ready <= w_start_ready;
      end
   end

   assign bus.key_wr      = r_key_wr;
   assign bus.key_sel     = r_key_sel;
   assign bus.rk_sel      = r_rk_sel;
   assign bus.sub_en      = r_sub_en;
   assign bus.shift_en    = r_shift_en;
   assign bus.mix_en      = r_mix_en;
   assign bus.ark_en      = r_ark_en;
   assign bus.busy        = r_busy;
   assign bus.done_valid  = r_done_valid;
   assign bus.start_ready = r_start_ready;
   // Plaintext capture strobe on the accept cycle.
   assign bus.state_load  = bus.start & r_start_ready;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed + randomized bench for aes_round_ctrl (KEXP_CYCLES=1 and =3 instances).
module tb_aes_round_ctrl;

   localparam logic [15:0] IDLE_V = 16'h8000;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   aes_round_ctrl_if #(.ROUND_W(4)) ifa ();
   aes_round_ctrl_if #(.ROUND_W(4)) ifb ();

   aes_round_ctrl #(.NUM_ROUNDS(10), .ROUND_W(4), .KEXP_CYCLES(1)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .bus(ifa)
   );
   aes_round_ctrl #(.NUM_ROUNDS(10), .ROUND_W(4), .KEXP_CYCLES(3)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .bus(ifb)
   );

   // Observed outputs packed as {start_ready,busy,done_valid,key_wr,key_sel,rk_sel,sub,shift,mix,ark}.
   function automatic logic [15:0] obs(input int sel);
      if (sel == 0)
         return {ifa.start_ready, ifa.busy, ifa.done_valid, ifa.key_wr, ifa.key_sel,
                 ifa.rk_sel, ifa.sub_en, ifa.shift_en, ifa.mix_en, ifa.ark_en};
      return {ifb.start_ready, ifb.busy, ifb.done_valid, ifb.key_wr, ifb.key_sel,
              ifb.rk_sel, ifb.sub_en, ifb.shift_en, ifb.mix_en, ifb.ark_en};
   endfunction

   function automatic logic get_load(input int sel);
      return (sel == 0) ? ifa.state_load : ifb.state_load;
   endfunction

   // Reference schedule: cycle t after the accept edge, k cycles per key step, 10 rounds.
   function automatic logic [15:0] model(input int t, input int k);
      int          nk = 11 * k;
      logic [15:0] v  = 16'h4000;
      if (t <= nk) begin
         v[12]   = ((t % k) == 0);
         v[11:8] = 4'((t - 1) / k);
      end else if (t == nk + 1) begin
         v[0] = 1'b1;
      end else if (t <= nk + 10) begin
         v[7:4] = 4'(t - nk - 1);
         v[3:0] = 4'b1111;
      end else if (t == nk + 11) begin
         v[7:4] = 4'd10;
         v[3:0] = 4'b1101;
      end else begin
         v[13] = 1'b1;
      end
      return v;
   endfunction

   task automatic check(input string tag, input logic [15:0] o, input logic [15:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, o, e);
      end
   endtask

   task automatic set_in(input int sel, input logic s, input logic d);
      if (sel == 0) begin
         ifa.start = s; ifa.done_ready = d;
      end else begin
         ifb.start = s; ifb.done_ready = d;
      end
   endtask

   // One block from an idle negedge; ends on the negedge where the DUT is idle again.
   task automatic run_block(input int sel, input int k, input int hold, input bit noisy);
      int          t_done = 11 * k + 12;
      int          pulses = 0;
      int          bad_idx = 0;
      logic [15:0] o;
      logic        d;
      o = obs(sel);
      check("idle_before_start", o, IDLE_V);
      d = noisy ? 1'($urandom_range(0, 1)) : 1'(hold == 0);
      set_in(sel, 1'b1, d);
      #1;
      check("state_load_accept", 16'(get_load(sel)), 16'h1);
      for (int t = 1; t <= t_done + hold + 1; t++) begin
         @(negedge clk);
         o = obs(sel);
         if (t == t_done + hold + 1) begin
            check("idle_after_done", o, IDLE_V);
            set_in(sel, 1'b0, 1'b0);
         end else begin
            check($sformatf("sched_k%0d_t%0d", k, t), o, model(t, k));
            if (o[12]) pulses++;
            if (o[11:8] > 4'd10 || o[7:4] > 4'd10) bad_idx++;
            if (t < t_done)
               d = noisy ? 1'($urandom_range(0, 1)) : 1'(hold == 0);
            else
               d = 1'(t >= t_done + hold);
            set_in(sel, noisy ? 1'($urandom_range(0, 1)) : 1'b0, d);
            #1;
            check("state_load_busy", 16'(get_load(sel)), 16'h0);
         end
      end
      check("key_wr_count", 16'(pulses), 16'd11);
      check("index_range", 16'(bad_idx), 16'd0);
   endtask

   initial begin
      logic [15:0] o;
      rst_n = 1'b1;
      set_in(0, 1'b0, 1'b0);
      set_in(1, 1'b0, 1'b0);
      #2 rst_n = 1'b0;

      // Reset held for three cycles.
      repeat (3) begin
         @(negedge clk);
         check("reset_a", obs(0), IDLE_V);
         check("reset_b", obs(1), IDLE_V);
      end
      rst_n = 1'b1;

      // Idle with start low.
      repeat (10) begin
         @(negedge clk);
         check("idle_a", obs(0), IDLE_V);
         check("idle_b", obs(1), IDLE_V);
         check("idle_load", 16'(get_load(0)), 16'h0);
      end

      // Single blocks with immediate acceptance.
      run_block(0, 1, 0, 1'b0);
      run_block(1, 3, 0, 1'b0);

      // Backpressure with ignored start pulses, then back-to-back blocks.
      run_block(0, 1, 5, 1'b1);
      run_block(0, 1, int'($urandom_range(0, 3)), 1'b1);
      run_block(1, 3, 5, 1'b1);

      // Reset during key expansion.
      check("idle_before_abort", obs(0), IDLE_V);
      set_in(0, 1'b1, 1'b0);
      for (int t = 1; t <= 6; t++) begin
         @(negedge clk);
         check($sformatf("abort_sched_t%0d", t), obs(0), model(t, 1));
         set_in(0, 1'b0, 1'b0);
      end
      rst_n = 1'b0;
      #1;
      o = obs(0);
      check("abort_key_wr", 16'(o[12]), 16'h0);
      check("abort_idle", o, IDLE_V);
      repeat (2) @(negedge clk);
      check("abort_held", obs(0), IDLE_V);
      rst_n = 1'b1;
      @(negedge clk);
      run_block(0, 1, 0, 1'b0);

      // Randomized blocks across both instances.
      for (int i = 0; i < 6; i++) begin
         int sel;
         sel = int'($urandom_range(0, 1));
         run_block(sel, (sel == 0) ? 1 : 3, int'($urandom_range(0, 4)), 1'b1);
         repeat (int'($urandom_range(0, 2))) begin
            @(negedge clk);
            check("gap_idle", obs(sel), IDLE_V);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
